// File: rtl/fft_sequencer_if.sv
// fft_sequencer_if: control, load, butterfly-issue and readout signals of the FFT sequencer
interface fft_sequencer_if;
    logic       start;
    logic       in_valid;
    logic       load_ready;
    logic       ld_we;
    logic [5:0] ld_addr;
    logic       bf_valid;
    logic [5:0] bf_addr_a;
    logic [5:0] bf_addr_b;
    logic [4:0] bf_tw;
    logic [2:0] bf_stage;
    logic       dataind;
    logic       out_rd_en;
    logic [5:0] out_rd_addr;
    logic       busy;
    logic       done;
    modport master (
        output start, in_valid,
        input  load_ready, ld_we, ld_addr, bf_valid, bf_addr_a, bf_addr_b, bf_tw, bf_stage,
        input  dataind, out_rd_en, out_rd_addr, busy, done
    );
    modport slave (
        input  start, in_valid,
        output load_ready, ld_we, ld_addr, bf_valid, bf_addr_a, bf_addr_b, bf_tw, bf_stage,
        output dataind, out_rd_en, out_rd_addr, busy, done
    );
endinterface

// File: rtl/fft_sequencer.sv
// fft_sequencer: frame control for a 64-point radix-2 DIT FFT (bit-reversed load, 6x32 butterflies, natural-order readout)
module fft_sequencer #(
    parameter int BF_LAT = 3
) (
    input logic           clk,
    input logic           rst,
    fft_sequencer_if.slave io
);
    typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, DRAIN, OUTPUT} state_t;
    state_t     state_q, state_d;
    logic [5:0] ld_cnt_q, ld_cnt_d;
    logic [4:0] b_q, b_d;
    logic [2:0] s_q, s_d;
    logic [3:0] drn_q, drn_d;
    logic [6:0] out_cnt_q, out_cnt_d;
    logic       bf_valid_q, bf_valid_d;
    logic [5:0] bf_addr_a_q, bf_addr_a_d;
    logic [5:0] bf_addr_b_q, bf_addr_b_d;
    logic [4:0] bf_tw_q, bf_tw_d;
    logic [2:0] bf_stage_q, bf_stage_d;
    logic       dataind_q, dataind_d;
    logic       out_rd_en_q, out_rd_en_d;
    logic [5:0] out_rd_addr_q, out_rd_addr_d;
    logic       done_q, done_d;
    logic [5:0] half, a_addr;
    logic [4:0] pos;
    always_comb begin
        state_d   = state_q;
        ld_cnt_d  = 6'd0;
        b_d       = 5'd0;
        s_d       = s_q;
        drn_d     = 4'd0;
        out_cnt_d = 7'd0;
        half      = 6'd1 << s_q;
        pos       = b_q & (half[4:0] - 5'd1);
        a_addr    = ((({1'b0, b_q} >> s_q) << s_q) << 1) | {1'b0, pos};
        bf_valid_d    = state_q == COMPUTE;
        bf_addr_a_d   = bf_valid_d ? a_addr : 6'd0;
        bf_addr_b_d   = bf_valid_d ? (a_addr | half) : 6'd0;
        bf_tw_d       = bf_valid_d ? (pos << (3'd5 - s_q)) : 5'd0;
        bf_stage_d    = bf_valid_d ? s_q : 3'd0;
        dataind_d     = state_q == OUTPUT && out_cnt_q == 7'd0;
        out_rd_en_d   = state_q == OUTPUT && out_cnt_q != 7'd64;
        out_rd_addr_d = out_rd_en_d ? out_cnt_q[5:0] : 6'd0;
        done_d        = state_q == OUTPUT && out_cnt_q == 7'd64;
        case (state_q)
            IDLE: begin
                s_d     = 3'd0;
                state_d = io.start ? LOAD : IDLE;
            end
            LOAD: begin
                ld_cnt_d = io.in_valid ? ld_cnt_q + 6'd1 : ld_cnt_q;
                state_d  = (io.in_valid && ld_cnt_q == 6'd63) ? COMPUTE : LOAD;
            end
            COMPUTE: begin
                b_d = b_q + 5'd1;
                if (b_q == 5'd31) begin
                    if (BF_LAT > 0) state_d = DRAIN;
                    else if (s_q == 3'd5) state_d = OUTPUT;
                    else s_d = s_q + 3'd1;
                end
            end
            DRAIN: begin
                drn_d = drn_q + 4'd1;
                if (drn_q == 4'(BF_LAT - 1)) begin
                    drn_d   = 4'd0;
                    state_d = s_q == 3'd5 ? OUTPUT : COMPUTE;
                    s_d     = s_q == 3'd5 ? s_q : s_q + 3'd1;
                end
            end
            OUTPUT: begin
                out_cnt_d = out_cnt_q + 7'd1;
                if (out_cnt_q == 7'd64) begin
                    out_cnt_d = 7'd0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            ld_cnt_q      <= 6'd0;
            b_q           <= 5'd0;
            s_q           <= 3'd0;
            drn_q         <= 4'd0;
            out_cnt_q     <= 7'd0;
            bf_valid_q    <= 1'b0;
            bf_addr_a_q   <= 6'd0;
            bf_addr_b_q   <= 6'd0;
            bf_tw_q       <= 5'd0;
            bf_stage_q    <= 3'd0;
            dataind_q     <= 1'b0;
            out_rd_en_q   <= 1'b0;
            out_rd_addr_q <= 6'd0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ld_cnt_q      <= ld_cnt_d;
            b_q           <= b_d;
            s_q           <= s_d;
            drn_q         <= drn_d;
            out_cnt_q     <= out_cnt_d;
            bf_valid_q    <= bf_valid_d;
            bf_addr_a_q   <= bf_addr_a_d;
            bf_addr_b_q   <= bf_addr_b_d;
            bf_tw_q       <= bf_tw_d;
            bf_stage_q    <= bf_stage_d;
            dataind_q     <= dataind_d;
            out_rd_en_q   <= out_rd_en_d;
            out_rd_addr_q <= out_rd_addr_d;
            done_q        <= done_d;
        end
    end
    assign io.load_ready  = state_q == LOAD;
    assign io.ld_we       = io.in_valid && state_q == LOAD;
    assign io.ld_addr     = {ld_cnt_q[0], ld_cnt_q[1], ld_cnt_q[2], ld_cnt_q[3], ld_cnt_q[4], ld_cnt_q[5]};
    assign io.busy        = state_q != IDLE;
    assign io.bf_valid    = bf_valid_q;
    assign io.bf_addr_a   = bf_addr_a_q;
    assign io.bf_addr_b   = bf_addr_b_q;
    assign io.bf_tw       = bf_tw_q;
    assign io.bf_stage    = bf_stage_q;
    assign io.dataind     = dataind_q;
    assign io.out_rd_en   = out_rd_en_q;
    assign io.out_rd_addr = out_rd_addr_q;
    assign io.done        = done_q;
endmodule

// File: tb/tb_fft_sequencer.sv
// tb_fft_sequencer: randomized frame stimulus checked against a butterfly-pair and bit-reversal reference model
module tb_fft_sequencer;
    localparam int BF_LAT = 3;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    fft_sequencer_if io();
    fft_sequencer_if iz();
    fft_sequencer #(.BF_LAT(BF_LAT)) dut (.clk(clk), .rst(rst), .io(io));
    fft_sequencer #(.BF_LAT(0)) dut0 (.clk(clk), .rst(rst), .io(iz));
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t_start = 0;
    int n_load = 0;
    always @(posedge clk) cyc <= cyc + 1;
    typedef struct {int st; int a; int b; int tw;} bf_t;
    bf_t exp_q[$];
    function automatic int bitrev6(input int v);
        int r = 0;
        for (int i = 0; i < 6; i++) if (((v >> i) & 1) == 1) r += 1 << (5 - i);
        return r;
    endfunction
    // DIT pairs: at stage s every index i with bit s clear pairs with i+2^s, twiddle stride 32/2^s
    function automatic void build_model();
        for (int s = 0; s < 6; s++) begin
            int half = 1 << s;
            for (int i = 0; i < 64; i++)
                if ((i / half) % 2 == 0) exp_q.push_back('{s, i, i + half, (i % half) * (32 / half)});
        end
    endfunction
    task automatic do_start();
        io.start = 1'b1;
        io.in_valid = 1'b0;
        t_start = cyc;
        @(negedge clk);
        io.start = 1'b0;
    endtask
    task automatic do_load(input int max_gap);
        int k = 0;
        int nwe = 0;
        int gap = $urandom_range(0, max_gap);
        n_load = 0;
        while (k < 64 && n_load < 400) begin
            n_load++;
            checks++;
            if (io.load_ready !== 1'b1) begin errors++; $display("FAIL load_ready: got %b want 1 at sample %0d", io.load_ready, k); end
            io.start = 1'($urandom_range(0, 1));
            io.in_valid = gap == 0;
            #1;
            if (io.ld_we === 1'b1) nwe++;
            checks++;
            if (gap == 0) begin
                if (io.ld_we !== 1'b1 || io.ld_addr !== 6'(bitrev6(k))) begin
                    errors++; $display("FAIL ld_addr: sample %0d got we=%b addr=%0d want we=1 addr=%0d", k, io.ld_we, io.ld_addr, bitrev6(k));
                end
                k++;
                gap = $urandom_range(0, max_gap);
            end else begin
                if (io.ld_we !== 1'b0) begin errors++; $display("FAIL ld_we_gap: got %b want 0", io.ld_we); end
                gap--;
            end
            @(negedge clk);
        end
        checks++;
        if (nwe != 64) begin errors++; $display("FAIL ld_we_count: got %0d want 64", nwe); end
    endtask
    task automatic do_compute(input int rst_at);
        int idx = 0;
        int zeros = 0;
        int cnt = 0;
        int limit = rst_at < 0 ? 192 : rst_at;
        bf_t e;
        while (idx < limit && cnt < 600) begin
            cnt++;
            io.start = 1'($urandom_range(0, 1));
            io.in_valid = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (io.ld_we !== 1'b0) begin errors++; $display("FAIL ld_we_compute: got %b want 0", io.ld_we); end
            if (io.bf_valid === 1'b1) begin
                if (idx > 0) begin
                    checks++;
                    if (zeros != ((idx % 32 == 0) ? BF_LAT : 0)) begin
                        errors++; $display("FAIL stage_gap: before issue %0d got %0d idle cycles want %0d", idx, zeros, (idx % 32 == 0) ? BF_LAT : 0);
                    end
                end
                e = exp_q[idx];
                checks++;
                if (io.bf_stage !== 3'(e.st) || io.bf_addr_a !== 6'(e.a) || io.bf_addr_b !== 6'(e.b) || io.bf_tw !== 5'(e.tw)) begin
                    errors++; $display("FAIL bf_issue %0d: got s%0d (%0d,%0d,tw%0d) want s%0d (%0d,%0d,tw%0d)", idx,
                        io.bf_stage, io.bf_addr_a, io.bf_addr_b, io.bf_tw, e.st, e.a, e.b, e.tw);
                end
                idx++;
                zeros = 0;
                if (idx >= limit) break;
            end else if (idx > 0) zeros++;
            @(negedge clk);
        end
        checks++;
        if (idx != limit) begin errors++; $display("FAIL bf_count: got %0d want %0d", idx, limit); end
        if (rst_at < 0) @(negedge clk);
    endtask
    task automatic do_output(input bit start_at_done);
        int cnt = 0;
        while (io.dataind !== 1'b1 && cnt < BF_LAT + 5) begin
            cnt++;
            io.start = 1'($urandom_range(0, 1));
            io.in_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        checks++;
        if (cnt != BF_LAT || io.dataind !== 1'b1) begin
            errors++; $display("FAIL drain_to_dataind: got %0d cycles dataind=%b want %0d cycles dataind=1", cnt, io.dataind, BF_LAT);
            return;
        end
        for (int i = 0; i < 64; i++) begin
            checks++;
            if ({io.out_rd_en, io.out_rd_addr, io.dataind, io.done, io.bf_valid} !== {1'b1, 6'(i), i == 0, 1'b0, 1'b0}) begin
                errors++; $display("FAIL out_seq %0d: got en=%b addr=%0d dind=%b done=%b bfv=%b want en=1 addr=%0d dind=%b done=0 bfv=0",
                    i, io.out_rd_en, io.out_rd_addr, io.dataind, io.done, io.bf_valid, i, i == 0);
            end
            io.start = 1'($urandom_range(0, 1));
            io.in_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        checks++;
        if ({io.done, io.out_rd_en, io.busy, io.dataind} !== 4'b1000) begin
            errors++; $display("FAIL done_cycle: got done=%b en=%b busy=%b dind=%b want 1 0 0 0", io.done, io.out_rd_en, io.busy, io.dataind);
        end
        checks++;
        if (cyc - t_start != 1 + n_load + 6 * (32 + BF_LAT) + 64 + 1) begin
            errors++; $display("FAIL latency: got %0d want %0d", cyc - t_start, 1 + n_load + 6 * (32 + BF_LAT) + 64 + 1);
        end
        io.start = start_at_done;
        io.in_valid = 1'b0;
        if (start_at_done) t_start = cyc;
        @(negedge clk);
        io.start = 1'b0;
        checks++;
        if (io.done !== 1'b0 || io.busy !== start_at_done || io.load_ready !== start_at_done) begin
            errors++; $display("FAIL after_done: got done=%b busy=%b ready=%b want 0 %b %b", io.done, io.busy, io.load_ready, start_at_done, start_at_done);
        end
    endtask
    task automatic test_reset();
        rst = 1'b1;
        io.start = 1'b1; io.in_valid = 1'b1;
        iz.start = 1'b0; iz.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({io.load_ready, io.ld_we, io.ld_addr, io.bf_valid, io.bf_addr_a, io.bf_addr_b, io.bf_tw, io.bf_stage,
             io.dataind, io.out_rd_en, io.out_rd_addr, io.busy, io.done} !== 44'd0) begin
            errors++; $display("FAIL reset_outputs: got ready=%b we=%b busy=%b bfv=%b en=%b done=%b want all 0",
                io.load_ready, io.ld_we, io.busy, io.bf_valid, io.out_rd_en, io.done);
        end
        rst = 1'b0;
        io.start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (io.busy !== 1'b0 || io.load_ready !== 1'b0 || io.ld_we !== 1'b0) begin
            errors++; $display("FAIL idle_hold: got busy=%b ready=%b we=%b want 0 0 0", io.busy, io.load_ready, io.ld_we);
        end
        io.in_valid = 1'b0;
        @(negedge clk);
    endtask
    task automatic test_load_gaps();
        do_start();
        do_load(2);
        io.in_valid = 1'b1;
        io.start = 1'b1;
        #1;
        checks++;
        if (io.ld_we !== 1'b0 || io.busy !== 1'b1 || io.load_ready !== 1'b0) begin
            errors++; $display("FAIL extra_in_valid: got we=%b busy=%b ready=%b want 0 1 0", io.ld_we, io.busy, io.load_ready);
        end
        @(negedge clk);
    endtask
    task automatic test_stage_addressing();
        do_compute(-1);
    endtask
    task automatic test_output();
        do_output(1'b0);
    endtask
    task automatic test_back_to_back();
        do_start();
        do_load(0);
        do_compute(-1);
        do_output(1'b1);
        do_load(1);
        do_compute(-1);
        do_output(1'b0);
    endtask
    task automatic test_reset_mid_compute();
        do_start();
        do_load(1);
        do_compute(3 * 32 + 17);
        rst = 1'b1;
        io.start = 1'b1;
        io.in_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        io.start = 1'b0;
        io.in_valid = 1'b0;
        checks++;
        if ({io.bf_valid, io.busy, io.load_ready, io.out_rd_en, io.bf_addr_a, io.bf_stage} !== 13'd0) begin
            errors++; $display("FAIL mid_reset: got bfv=%b busy=%b ready=%b en=%b a=%0d s=%0d want all 0",
                io.bf_valid, io.busy, io.load_ready, io.out_rd_en, io.bf_addr_a, io.bf_stage);
        end
        @(negedge clk);
        checks++;
        if (io.busy !== 1'b0) begin errors++; $display("FAIL rst_with_start: got busy=%b want 0", io.busy); end
        do_start();
        do_load(0);
        do_compute(-1);
        do_output(1'b0);
    endtask
    task automatic test_bf_lat0();
        int w = 0;
        bf_t e;
        iz.start = 1'b1;
        @(negedge clk);
        iz.start = 1'b0;
        iz.in_valid = 1'b1;
        repeat (64) @(negedge clk);
        iz.in_valid = 1'b0;
        while (iz.bf_valid !== 1'b1 && w < 10) begin w++; @(negedge clk); end
        for (int i = 0; i < 192; i++) begin
            e = exp_q[i];
            checks++;
            if (iz.bf_valid !== 1'b1 || iz.bf_stage !== 3'(e.st) || iz.bf_addr_a !== 6'(e.a) || iz.bf_addr_b !== 6'(e.b) || iz.bf_tw !== 5'(e.tw)) begin
                errors++; $display("FAIL lat0_issue %0d: got v=%b s%0d (%0d,%0d,tw%0d) want v=1 s%0d (%0d,%0d,tw%0d)", i,
                    iz.bf_valid, iz.bf_stage, iz.bf_addr_a, iz.bf_addr_b, iz.bf_tw, e.st, e.a, e.b, e.tw);
            end
            @(negedge clk);
        end
        checks++;
        if (iz.bf_valid !== 1'b0 || iz.dataind !== 1'b1 || iz.out_rd_addr !== 6'd0) begin
            errors++; $display("FAIL lat0_dataind: got bfv=%b dind=%b addr=%0d want 0 1 0", iz.bf_valid, iz.dataind, iz.out_rd_addr);
        end
    endtask
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end
    initial begin
        build_model();
        test_reset();
        test_load_gaps();
        test_stage_addressing();
        test_output();
        test_back_to_back();
        test_reset_mid_compute();
        test_bf_lat0();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fft_sequencer.md
Name: fft_sequencer

Overview:
Top-level control for the 64-point radix-2 DIT FFT processor. Sequences one frame through three phases: load 64 samples into working RAM in bit-reversed order, issue 6 stages × 32 butterflies with RAM address and twiddle index generation, then stream results out in natural order. At output start it pulses dataind to the output sample counter.

Parameters:
BF_LAT, 3, butterfly pipeline latency in cycles; idle cycles inserted after each stage before the next stage issues (0 allowed, 0..15 supported)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start  in  1  begin a frame; honoured only in IDLE
in_valid  in  1  input sample strobe
load_ready  out  1  high while in LOAD
ld_we  out  1  RAM write enable for input sample (combinational: in_valid & LOAD)
ld_addr  out  6  RAM write address = bitrev6(load count) (combinational)
bf_valid  out  1  butterfly issue strobe (registered)
bf_addr_a  out  6  butterfly upper operand address (registered)
bf_addr_b  out  6  butterfly lower operand address (registered)
bf_tw  out  5  twiddle ROM index (registered)
bf_stage  out  3  current stage 0..5 (registered)
dataind  out  1  one-cycle pulse marking output start (registered)
out_rd_en  out  1  output RAM read enable (registered)
out_rd_addr  out  6  output RAM read address, natural order (registered)
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at frame end (registered)

Behaviour:
- States: IDLE, LOAD, COMPUTE, DRAIN, OUTPUT. Reset → IDLE, all counters 0, every registered output 0; load_ready, ld_we, busy 0.
- IDLE: start=1 → LOAD next cycle. start in any other state ignored.
- LOAD: each cycle with in_valid=1 writes at ld_addr and increments the 6-bit load count. Gaps allowed. The 64th accepted sample (count 63) → COMPUTE next cycle. in_valid outside LOAD ignored, no write.
- COMPUTE: one butterfly per cycle, index b=0..31, stage s. The registered outputs present butterfly b one cycle after the FSM issues it.
  - half = 1<<s; pos = b & (half-1); grp = b>>s
  - a = grp*2*half + pos; b_addr = a + half
  - tw = pos << (5-s), 5-bit
  - bf_valid=1 for each issue.
  - After b=31: if BF_LAT>0 go to DRAIN, else go straight to the next stage's b=0.
- DRAIN: bf_valid=0 for exactly BF_LAT cycles, then s+1 and COMPUTE with b=0.
  - After stage 5 completes (including its drain), go to OUTPUT.
  - Stage 5 always drains, so results are settled before readout.
- OUTPUT:
  - First cycle: dataind=1 for exactly one cycle, coincident with out_rd_en=1, out_rd_addr=0.
  - out_rd_addr increments each cycle, 0..63 over 64 consecutive cycles.
  - The cycle after addr 63: out_rd_en=0, done=1 for one cycle, state IDLE.
- Phase timing: compute phase issues 6×(32+BF_LAT) cycles (210 at default). Output phase is 64 cycles plus 1 cycle for done.
- A new start is accepted in the same cycle done is high, because the state is already IDLE.
- rst in any state, including mid-stage or mid-output, takes priority over all inputs. Next cycle: IDLE, all outputs at reset values, frame discarded. rst and start in the same cycle → IDLE.
- Counters never wrap silently. The load count and b terminate at 63 and 31 respectively and are cleared on state entry.

Test Plan:
1. Reset: hold rst 2 cycles with start=1 and in_valid=1 → all outputs 0, busy=0; stays IDLE after release until start.
2. Load with gaps: start, then 64 in_valid pulses with random 0–2 cycle gaps → ld_addr sequence 0,32,16,48,8,40,… ending 63; ld_we count = 64; extra in_valid after the 64th → no ld_we, busy=1.
3. Stage addressing:
   - Stage 0: b0 → (0,1,tw0), b1 → (2,3,tw0).
   - Stage 2: b5 → (9,13,tw8).
   - Stage 5: b5 → (5,37,tw5).
   - Exactly 3 bf_valid=0 cycles between stages; 192 bf_valid cycles total.
4. Output: after stage 5 drain, dataind single pulse with out_rd_addr=0; addresses 0..63 contiguous; done pulses once, the cycle after addr 63; start-to-done latency = 1 + load cycles + 210 + 64 + 1 with BF_LAT=3.
5. Reset mid-compute: assert rst during stage 3, b=17 → next cycle IDLE, bf_valid=0; fresh frame completes with correct stage-0 addresses.
6. start during LOAD/COMPUTE/OUTPUT → no effect. start coincident with done → new LOAD begins next cycle. BF_LAT=0 build → 192 contiguous bf_valid cycles.
